// File: rtl/cim_cmd_seq.sv
// cim_cmd_seq: expands host MAC / WRITE / READ commands into the per-cycle CIM array controller stream.
// Defining CIM_CMD_SKID_EN adds a one-entry command buffer so a new command can launch without a gap cycle.
module cim_cmd_seq #(
    parameter int ACT_BITS = 4,
    parameter int ROWS     = 16,
    parameter int READ_LAT = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_type,
    input  logic [3:0]                   cmd_bank,
    input  logic [2:0]                   cmd_col,
    input  logic [ROWS-1:0]              cmd_wdata,
    input  logic [ROWS*ACT_BITS-1:0]     cmd_act,
    input  logic                         abort,
    output logic [1:0]                   op_code,
    output logic [3:0]                   addr_bank,
    output logic [2:0]                   addr_col,
    output logic [ROWS-1:0]              data_bank,
    output logic [ROWS-1:0]              data_in,
    output logic [$clog2(ACT_BITS)-1:0]  mac_bit,
    output logic                         mac_last,
    output logic                         busy,
    output logic                         done
);

    localparam int MBW = $clog2(ACT_BITS);
    localparam int WW  = (READ_LAT > 2) ? $clog2(READ_LAT) : 1;

    localparam logic [1:0] OP_MAC  = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;
    localparam logic [1:0] OP_NONE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_WRITE,
        S_READ,
        S_WAIT
    } state_t;

    state_t                     state_q, state_d;
    logic [ROWS-1:0]            wdata_q, wdata_d;
    logic [ROWS*ACT_BITS-1:0]   act_q, act_d;
    logic [WW-1:0]              wait_q, wait_d;

    logic [1:0]                 op_q, op_d;
    logic [3:0]                 bank_q, bank_d;
    logic [2:0]                 col_q, col_d;
    logic [ROWS-1:0]            dbank_q, dbank_d;
    logic [ROWS-1:0]            din_q, din_d;
    logic [MBW-1:0]             mbit_q, mbit_d;
    logic                       last_q, last_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic                       accept;
    logic                       finish;
    logic                       l_en;
    logic [1:0]                 l_type;
    logic [3:0]                 l_bank;
    logic [2:0]                 l_col;
    logic [ROWS-1:0]            l_wdata;
    logic [ROWS*ACT_BITS-1:0]   l_act;
    logic [MBW-1:0]             mbit_inc;

`ifdef CIM_CMD_SKID_EN
    logic                       buf_vld_q, buf_vld_d;
    logic [1:0]                 buf_type_q, buf_type_d;
    logic [3:0]                 buf_bank_q, buf_bank_d;
    logic [2:0]                 buf_col_q, buf_col_d;
    logic [ROWS-1:0]            buf_wdata_q, buf_wdata_d;
    logic [ROWS*ACT_BITS-1:0]   buf_act_q, buf_act_d;
    // A buffered NOP launching on a finish cycle owes its own done pulse one cycle later.
    logic                       pend_q, pend_d;

    assign cmd_ready = ~buf_vld_q;
`else
    assign cmd_ready = (state_q == S_IDLE);
`endif

    assign accept    = cmd_valid & cmd_ready;
    assign mbit_inc  = mbit_q + 1'b1;

    assign op_code   = op_q;
    assign addr_bank = bank_q;
    assign addr_col  = col_q;
    assign data_bank = dbank_q;
    assign data_in   = din_q;
    assign mac_bit   = mbit_q;
    assign mac_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Outputs are registered, so the comb block computes what the array sees during the next state.
    always_comb begin
        state_d = state_q;
        wdata_d = wdata_q;
        act_d   = act_q;
        wait_d  = wait_q;
        op_d    = OP_NONE;
        bank_d  = '0;
        col_d   = '0;
        dbank_d = '0;
        din_d   = '0;
        mbit_d  = '0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        finish  = 1'b0;
        l_en    = 1'b0;
        l_type  = cmd_type;
        l_bank  = cmd_bank;
        l_col   = cmd_col;
        l_wdata = cmd_wdata;
        l_act   = cmd_act;
`ifdef CIM_CMD_SKID_EN
        buf_vld_d   = buf_vld_q;
        buf_type_d  = buf_type_q;
        buf_bank_d  = buf_bank_q;
        buf_col_d   = buf_col_q;
        buf_wdata_d = buf_wdata_q;
        buf_act_d   = buf_act_q;
        pend_d      = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    l_en = 1'b1;
                end
            end
            S_MAC: begin
                if (mbit_q == MBW'(ACT_BITS - 1)) begin
                    finish = 1'b1;
                end else begin
                    state_d = S_MAC;
                    op_d    = OP_MAC;
                    dbank_d = wdata_q;
                    mbit_d  = mbit_inc;
                    din_d   = act_q[mbit_inc*ROWS +: ROWS];
                    last_d  = (mbit_inc == MBW'(ACT_BITS - 1));
                    busy_d  = 1'b1;
                end
            end
            S_WRITE: begin
                finish = 1'b1;
            end
            S_READ: begin
                if (READ_LAT > 1) begin
                    state_d = S_WAIT;
                    wait_d  = WW'(READ_LAT - 2);
                    busy_d  = 1'b1;
                end else begin
                    finish = 1'b1;
                end
            end
            S_WAIT: begin
                if (wait_q == '0) begin
                    finish = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    wait_d  = wait_q - 1'b1;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (finish) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
`ifdef CIM_CMD_SKID_EN
            if (buf_vld_q) begin
                l_en      = 1'b1;
                l_type    = buf_type_q;
                l_bank    = buf_bank_q;
                l_col     = buf_col_q;
                l_wdata   = buf_wdata_q;
                l_act     = buf_act_q;
                buf_vld_d = 1'b0;
            end else if (accept) begin
                l_en = 1'b1;
            end
`endif
        end
`ifdef CIM_CMD_SKID_EN
        else if (accept && state_q != S_IDLE) begin
            buf_vld_d   = 1'b1;
            buf_type_d  = cmd_type;
            buf_bank_d  = cmd_bank;
            buf_col_d   = cmd_col;
            buf_wdata_d = cmd_wdata;
            buf_act_d   = cmd_act;
        end
        if (pend_q) begin
            done_d = 1'b1;
        end
`endif

        if (l_en) begin
            wdata_d = l_wdata;
            act_d   = l_act;
            case (l_type)
                2'b00: begin
                    state_d = S_MAC;
                    op_d    = OP_MAC;
                    dbank_d = l_wdata;
                    din_d   = l_act[ROWS-1:0];
                    mbit_d  = '0;
                    busy_d  = 1'b1;
                end
                2'b01: begin
                    state_d      = S_WRITE;
                    op_d         = OP_WR;
                    bank_d       = l_bank;
                    dbank_d[7:0] = l_wdata[7:0];
                    busy_d       = 1'b1;
                end
                2'b10: begin
                    state_d      = S_READ;
                    op_d         = OP_RD;
                    bank_d       = l_bank;
                    col_d        = l_col;
                    dbank_d[3:0] = l_wdata[3:0];
                    busy_d       = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
`ifdef CIM_CMD_SKID_EN
                    if (finish) begin
                        pend_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
`else
                    done_d = 1'b1;
`endif
                end
            endcase
        end

        // Abort outranks every transition above, including a completing cycle.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            op_d    = OP_NONE;
            bank_d  = '0;
            col_d   = '0;
            dbank_d = '0;
            din_d   = '0;
            mbit_d  = '0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
`ifdef CIM_CMD_SKID_EN
            buf_vld_d = 1'b0;
            pend_d    = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wdata_q <= '0;
            act_q   <= '0;
            wait_q  <= '0;
            op_q    <= OP_NONE;
            bank_q  <= '0;
            col_q   <= '0;
            dbank_q <= '0;
            din_q   <= '0;
            mbit_q  <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wdata_q <= wdata_d;
            act_q   <= act_d;
            wait_q  <= wait_d;
            op_q    <= op_d;
            bank_q  <= bank_d;
            col_q   <= col_d;
            dbank_q <= dbank_d;
            din_q   <= din_d;
            mbit_q  <= mbit_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef CIM_CMD_SKID_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_vld_q   <= 1'b0;
            buf_type_q  <= '0;
            buf_bank_q  <= '0;
            buf_col_q   <= '0;
            buf_wdata_q <= '0;
            buf_act_q   <= '0;
            pend_q      <= 1'b0;
        end else begin
            buf_vld_q   <= buf_vld_d;
            buf_type_q  <= buf_type_d;
            buf_bank_q  <= buf_bank_d;
            buf_col_q   <= buf_col_d;
            buf_wdata_q <= buf_wdata_d;
            buf_act_q   <= buf_act_d;
            pend_q      <= pend_d;
        end
    end
`endif

endmodule

// File: tb/tb_cim_cmd_seq.sv
// tb_cim_cmd_seq: directed stimulus for cim_cmd_seq checked every cycle against a queue-based
// command-expansion model, plus literal expectations from hand-worked vectors.
module tb_cim_cmd_seq;

    localparam int A = 4;
    localparam int R = 16;
    localparam int L = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_type = 2'b11;
    logic [3:0]       cmd_bank = '0;
    logic [2:0]       cmd_col = '0;
    logic [R-1:0]     cmd_wdata = '0;
    logic [R*A-1:0]   cmd_act = '0;
    logic             abort = 1'b0;
    logic [1:0]       op_code;
    logic [3:0]       addr_bank;
    logic [2:0]       addr_col;
    logic [R-1:0]     data_bank;
    logic [R-1:0]     data_in;
    logic [$clog2(A)-1:0] mac_bit;
    logic             mac_last;
    logic             busy;
    logic             done;

    cim_cmd_seq #(.ACT_BITS(A), .ROWS(R), .READ_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_bank(cmd_bank), .cmd_col(cmd_col),
        .cmd_wdata(cmd_wdata), .cmd_act(cmd_act), .abort(abort),
        .op_code(op_code), .addr_bank(addr_bank), .addr_col(addr_col),
        .data_bank(data_bank), .data_in(data_in), .mac_bit(mac_bit),
        .mac_last(mac_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int acc_cnt = 0;

    function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endfunction

    typedef struct {
        logic [1:0]           op;
        logic [3:0]           bank;
        logic [2:0]           col;
        logic [R-1:0]         dbank;
        logic [R-1:0]         din;
        logic [$clog2(A)-1:0] mbit;
        logic                 last;
        logic                 busy;
        logic                 done;
    } exp_t;

    function automatic exp_t idle_e();
        exp_t e;
        e.op = 2'b11; e.bank = '0; e.col = '0; e.dbank = '0; e.din = '0;
        e.mbit = '0; e.last = 1'b0; e.busy = 1'b0; e.done = 1'b0;
        return e;
    endfunction

    exp_t cur = idle_e();
    exp_t q[$];

    // Model: each accepted command becomes its list of array cycles followed by one done cycle.
    initial forever begin
        exp_t e;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete();
            cur = idle_e();
        end else begin
            if (abort && cur.busy) begin
                q.delete();
            end else if (cmd_valid && !cur.busy) begin
                acc_cnt++;
                case (cmd_type)
                    2'b00: for (int b = 0; b < A; b++) begin
                        e = idle_e(); e.op = 2'b00; e.dbank = cmd_wdata;
                        e.din = cmd_act[b*R +: R]; e.mbit = b[$clog2(A)-1:0];
                        e.last = (b == A - 1); e.busy = 1'b1; q.push_back(e);
                    end
                    2'b01: begin
                        e = idle_e(); e.op = 2'b01; e.bank = cmd_bank;
                        e.dbank = {8'h00, cmd_wdata[7:0]}; e.busy = 1'b1; q.push_back(e);
                    end
                    2'b10: begin
                        e = idle_e(); e.op = 2'b10; e.bank = cmd_bank; e.col = cmd_col;
                        e.dbank = {12'h000, cmd_wdata[3:0]}; e.busy = 1'b1; q.push_back(e);
                        for (int w = 1; w < L; w++) begin
                            e = idle_e(); e.busy = 1'b1; q.push_back(e);
                        end
                    end
                    default: ;
                endcase
                e = idle_e(); e.done = 1'b1; q.push_back(e);
            end
            cur = (q.size() != 0) ? q.pop_front() : idle_e();
        end
    end

    initial forever begin
        @(negedge clk);
        chk("op_code", op_code, cur.op);
        chk("addr_bank", addr_bank, cur.bank);
        chk("addr_col", addr_col, cur.col);
        chk("data_bank", data_bank, cur.dbank);
        chk("data_in", data_in, cur.din);
        chk("mac_bit", mac_bit, cur.mbit);
        chk("mac_last", mac_last, cur.last);
        chk("busy", busy, cur.busy);
        chk("done", done, cur.done);
        chk("cmd_ready", cmd_ready, !cur.busy);
    end

    task automatic wait_acc(input int s);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (acc_cnt != s) break;
        end
        chk("accept_seen", acc_cnt != s, 1);
    endtask

    task automatic issue(input logic [1:0] t, input logic [3:0] b, input logic [2:0] c,
                         input logic [R-1:0] w, input logic [R*A-1:0] a);
        int s;
        s = acc_cnt;
        cmd_type = t; cmd_bank = b; cmd_col = c; cmd_wdata = w; cmd_act = a;
        cmd_valid = 1'b1;
        wait_acc(s);
        cmd_valid = 1'b0;
        cmd_bank = ~b; cmd_col = ~c; cmd_wdata = ~w; cmd_act = ~a;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (!cur.busy && q.size() == 0) break;
            @(posedge clk); #1;
        end
        chk("idle_reached", !cur.busy && q.size() == 0, 1);
    endtask

    typedef struct {
        logic [1:0]     t;
        logic [3:0]     b;
        logic [2:0]     c;
        logic [R-1:0]   w;
        logic [R*A-1:0] a;
    } tv_t;

    tv_t tv[7];
    logic [R-1:0] planes[4];

    initial begin
        int s;
        int n;
        planes = '{16'hF000, 16'h0F00, 16'h00F0, 16'h000F};
        tv[0] = '{2'b00, 4'h0, 3'd0, 16'h1234, 64'h8001_7FFE_0000_FFFF};
        tv[1] = '{2'b10, 4'hF, 3'd7, 16'hFFFF, 64'h0};
        tv[2] = '{2'b01, 4'h0, 3'd0, 16'hFFFF, 64'h0};
        tv[3] = '{2'b10, 4'h0, 3'd0, 16'h0000, 64'h0};
        tv[4] = '{2'b00, 4'h4, 3'd2, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFF};
        tv[5] = '{2'b11, 4'h0, 3'd0, 16'h0000, 64'h0};
        tv[6] = '{2'b01, 4'hF, 3'd7, 16'h8000, 64'h0};

        #1 rst_n = 1'b0;
        #2;
        chk("rst_op", op_code, 2'b11);
        chk("rst_din", data_in, 16'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", cmd_ready, 1'b1);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // MAC with hand-worked planes
        issue(2'b00, 4'h0, 3'd0, 16'hA5A5, 64'h000F_00F0_0F00_F000);
        for (int b = 0; b < 4; b++) begin
            if (b != 0) begin @(posedge clk); #1; end
            chk("mac_op", op_code, 2'b00);
            chk("mac_dbank", data_bank, 16'hA5A5);
            chk("mac_plane", data_in, planes[b]);
            chk("mac_bit_lit", mac_bit, b);
            chk("mac_last_lit", mac_last, b == 3);
        end
        @(posedge clk); #1;
        chk("mac_done_op", op_code, 2'b11);
        chk("mac_done", done, 1'b1);
        @(posedge clk); #1;
        chk("mac_done_once", done, 1'b0);

        issue(2'b01, 4'd9, 3'd0, 16'h12C3, 64'h0);
        chk("wr_op", op_code, 2'b01);
        chk("wr_bank", addr_bank, 4'd9);
        chk("wr_dbank", data_bank, 16'h00C3);
        @(posedge clk); #1;
        chk("wr_done", done, 1'b1);

        issue(2'b10, 4'd3, 3'd5, 16'hFFF6, 64'h0);
        chk("rd_op", op_code, 2'b10);
        chk("rd_col", addr_col, 3'd5);
        chk("rd_dbank", data_bank, 16'h0006);
        @(posedge clk); #1;
        chk("rd_wait_op", op_code, 2'b11);
        chk("rd_wait_done", done, 1'b0);
        @(posedge clk); #1;
        chk("rd_done", done, 1'b1);

        // abort on the second MAC cycle, then a normal WRITE
        issue(2'b00, 4'h0, 3'd0, 16'h3C3C, 64'h1234_5678_9ABC_DEF0);
        @(posedge clk); #1;
        chk("ab_mbit", mac_bit, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("ab_op", op_code, 2'b11);
        chk("ab_busy", busy, 1'b0);
        chk("ab_done", done, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        issue(2'b01, 4'd2, 3'd0, 16'h00AB, 64'h0);
        chk("ab_wr_op", op_code, 2'b01);
        chk("ab_wr_dbank", data_bank, 16'h00AB);
        wait_idle();

        // abort in the READ wait cycle and on the final MAC plane
        issue(2'b10, 4'd1, 3'd1, 16'h0001, 64'h0);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("ab_rd_done", done, 1'b0);
        issue(2'b00, 4'h0, 3'd0, 16'h0001, 64'hAAAA_BBBB_CCCC_DDDD);
        repeat (3) @(posedge clk);
        #1;
        chk("ab_last", mac_last, 1'b1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("ab_last_done", done, 1'b0);
        chk("ab_last_flag", mac_last, 1'b0);

        // abort in IDLE is ignored, including alongside an accept
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        issue(2'b01, 4'd5, 3'd0, 16'h0077, 64'h0);
        abort = 1'b0;
        chk("idle_ab_op", op_code, 2'b01);
        wait_idle();

        // NOP then MAC with valid held, then a held WRITE behind the MAC
        s = acc_cnt;
        cmd_type = 2'b11; cmd_valid = 1'b1;
        wait_acc(s);
        chk("nop_done", done, 1'b1);
        cmd_type = 2'b00; cmd_wdata = 16'h0F0F; cmd_act = 64'h1111_2222_4444_8888;
        s = acc_cnt;
        @(posedge clk); #1;
        chk("nop_mac_acc", acc_cnt - s, 1);
        chk("nop_mac_din", data_in, 16'h8888);
        cmd_type = 2'b01; cmd_bank = 4'hC; cmd_wdata = 16'h5A5A;
        s = acc_cnt; n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            n++;
            if (acc_cnt != s) break;
        end
        cmd_valid = 1'b0;
        chk("held_wr_edges", n, 5);
        chk("held_wr_dbank", data_bank, 16'h005A);
        wait_idle();

        foreach (tv[i]) issue(tv[i].t, tv[i].b, tv[i].c, tv[i].w, tv[i].a);
        wait_idle();

        // asynchronous reset in the middle of a MAC
        issue(2'b00, 4'h0, 3'd0, 16'hBEEF, 64'hFEDC_BA98_7654_3210);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_mbit", mac_bit, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_op", op_code, 2'b11);
        chk("mid_rst_din", data_in, 16'h0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_mbit", mac_bit, 0);
        #3 rst_n = 1'b1;
        #1;
        chk("mid_rst_ready", cmd_ready, 1'b1);
        @(posedge clk); #1;
        issue(2'b01, 4'd7, 3'd0, 16'h00E1, 64'h0);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
